instr_fetch_reg: RTL
====================

// Module: instr_fetch_reg
// PURPOSE
// - Instruction memory plus fetch register directly downstream of the program counter.
// - Consumes the 10-bit ProgCtr index and presents one registered 9-bit instruction per cycle to decode.
// - Squashes the slot after a taken branch.
// - Run-control FSM: Start/Done handshake; detects the program's halt opcode.
// PARAMETERS
// - A_W     10         instruction address width; depth = 2**A_W
// - I_W     9          instruction width
// - HALT_OP 9'h1FF     opcode that ends a program
// - NOP_OP  9'h000     value presented on squashed/idle slots
// PORTS
// - Clk          in   1    single clock, all state on posedge
// - Reset        in   1    synchronous, active-high
// - Start        in   1    one-cycle pulse: begin program at ProgCtr=0
// - ProgCtr      in   A_W  fetch address from program counter
// - BranchTaken  in   1    branch/jump taken this cycle; squash next slot
// - LoadEn       in   1    memory write strobe (testbench/boot load)
// - LoadAddr     in   A_W  write address
// - LoadData     in   I_W  write data
// - Instruction  out  I_W  registered instruction to decode
// - InstrValid   out  1    Instruction is live and must execute
// - Running      out  1    FSM in FILL or RUN
// - Done         out  1    program reached HALT_OP; held until next Start
// BEHAVIOUR
// - Reset (any state, any cycle) -> IDLE.
//   - Instruction=NOP_OP, InstrValid=0, Running=0, Done=0.
//   - Memory contents are not cleared.
// - Read: registered, 1-cycle latency.
//   - Instruction at edge N+1 = mem[ProgCtr sampled at edge N].
// - States:
//   - IDLE: outputs idle. Start -> FILL.
//   - FILL: one cycle; read mem[ProgCtr] (PC is 0 after Start); InstrValid=0 -> RUN.
//   - RUN: each cycle Instruction<=mem[ProgCtr], InstrValid<=1.
//   - HALT: Done=1, Instruction=NOP_OP, InstrValid=0. Start -> FILL with Done cleared same edge.
// - RUN exit: on registered Instruction==HALT_OP with InstrValid=1.
//   - Next edge -> HALT.
//   - The HALT_OP slot itself is presented with InstrValid=1 for exactly one cycle.
// - Squash: BranchTaken=1 in RUN at edge N.
//   - Edge N+1 presents NOP_OP with InstrValid=0.
//   - Fetch resumes from the new ProgCtr at edge N+2.
//   - Back-to-back BranchTaken keeps squashing.
//   - A squashed HALT_OP does not halt.
// - Start while in FILL/RUN: ignored.
// - Start coincident with Reset: Reset wins.
// - LoadEn honoured only in IDLE/HALT; ignored in FILL/RUN.
//   - Load and Start on the same edge: write completes; fetch sees new data (write-first).
// - ProgCtr wraps naturally at 2**A_W; no bounds check.
// CONFIGURATION
// - FETCH_STATS_EN defined:
//   - Adds outputs CycleCount[15:0] and InstrCount[15:0].
//   - Both cleared on Start and Reset.
//   - CycleCount increments every cycle in FILL/RUN.
//   - InstrCount increments each cycle InstrValid=1.
//   - Both saturate at 16'hFFFF; values frozen in HALT.
// - FETCH_STATS_EN undefined: ports and counters absent; all other behaviour identical.
// TESTING
// - Reset: hold Reset 2 cycles -> Instruction=9'h000, InstrValid=0, Running=0, Done=0.
// - Load/run: load mem[0..2]=9'h011,9'h022,9'h1FF; pulse Start; PC 0,1,2 ->
//   FILL, then 9'h011, 9'h022, 9'h1FF valid on consecutive cycles; Done=1 next cycle.
// - Squash: load mem[1]=9'h0AA, mem[10]=9'h0BB; BranchTaken at PC=1, PC->10 ->
//   one cycle 9'h000/InstrValid=0, then 9'h0BB valid.
// - Reset mid-run: Reset at 3rd RUN cycle -> IDLE next edge;
//   mem[0]=9'h011 still reads back after new Start.
// - Guard: LoadEn in RUN to addr 5 -> mem[5] unchanged; Start in RUN -> no FILL.
// - FETCH_STATS_EN: 3-instruction program above -> InstrCount=3, CycleCount=4 in HALT.

Source files
------------

// File: rtl/instr_fetch_reg.sv
// Instruction memory with a registered fetch slot (1-cycle read latency), branch squash and Start/Done run control.
// FETCH_STATS_EN adds saturating CycleCount/InstrCount outputs.
module instr_fetch_reg #(
    parameter int               A_W     = 10,
    parameter int               I_W     = 9,
    parameter logic [I_W-1:0]   HALT_OP = 9'h1FF,
    parameter logic [I_W-1:0]   NOP_OP  = 9'h000
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [A_W-1:0]  ProgCtr,
    input  logic            BranchTaken,
    input  logic            LoadEn,
    input  logic [A_W-1:0]  LoadAddr,
    input  logic [I_W-1:0]  LoadData,
    output logic [I_W-1:0]  Instruction,
    output logic            InstrValid,
    output logic            Running,
    output logic            Done
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]     CycleCount,
    output logic [15:0]     InstrCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_HALT
    } state_t;

    state_t         state;
    logic           squash;
    logic [I_W-1:0] mem [2**A_W];

    logic stopped;
    logic load_ok;
    logic start_ok;
    logic halt_seen;

    assign stopped   = (state == S_IDLE) || (state == S_HALT);
    assign load_ok   = LoadEn && stopped;
    assign start_ok  = Start && stopped;
    assign halt_seen = (state == S_RUN) && InstrValid && (Instruction == HALT_OP);

    // No reset on the array: program contents survive Reset.
    always_ff @(posedge Clk) begin
        if (load_ok) begin
            mem[LoadAddr] <= LoadData;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= S_IDLE;
            Instruction <= NOP_OP;
            InstrValid  <= 1'b0;
            Running     <= 1'b0;
            Done        <= 1'b0;
            squash      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start_ok) begin
                        state   <= S_FILL;
                        Running <= 1'b1;
                        Done    <= 1'b0;
                    end
                end
                S_FILL: begin
                    Instruction <= mem[ProgCtr];
                    InstrValid  <= 1'b1;
                    squash      <= 1'b0;
                    state       <= S_RUN;
                end
                S_RUN: begin
                    if (halt_seen) begin
                        state       <= S_HALT;
                        Instruction <= NOP_OP;
                        InstrValid  <= 1'b0;
                        Running     <= 1'b0;
                        Done        <= 1'b1;
                        squash      <= 1'b0;
                    end else begin
                        // A squashed slot never reads memory, so a HALT_OP behind a branch is inert.
                        if (squash) begin
                            Instruction <= NOP_OP;
                            InstrValid  <= 1'b0;
                        end else begin
                            Instruction <= mem[ProgCtr];
                            InstrValid  <= 1'b1;
                        end
                        squash <= BranchTaken;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge Clk) begin
        if (Reset || start_ok) begin
            CycleCount <= '0;
            InstrCount <= '0;
        end else begin
            if (Running && (CycleCount != 16'hFFFF)) begin
                CycleCount <= CycleCount + 16'd1;
            end
            if (InstrValid && (InstrCount != 16'hFFFF)) begin
                InstrCount <= InstrCount + 16'd1;
            end
        end
    end
`endif

endmodule
